// File: rtl/apb_cfg_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_cfg_seq_pkg
// Description : Shared types for the APB configuration sequencer: FSM state
//               encoding, response error codes and the queued command record.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_cfg_seq_pkg;

  // Commands carry a full 32-bit address field. The top truncates it to
  // APB_ADDR_WIDTH, so any address width up to 32 bits fits.
  localparam int c_CMD_ADDR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_ACCESS    = 3'd2,
    ST_RB_SETUP  = 3'd3,
    ST_RB_ACCESS = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_SLVERR   = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_MISMATCH = 2'b11
  } err_e;

  typedef struct packed {
    logic                    write;
    logic [c_CMD_ADDR_W-1:0] addr;
    logic [31:0]             wdata;
  } cmd_t;

  // A readback mismatches when any bit selected by the mask differs from the
  // value that was written.
  function automatic logic rb_mismatch(input logic [31:0] rd,
                                       input logic [31:0] wr,
                                       input logic [31:0] mask);
    return ((rd ^ wr) & mask) != 32'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_cfg_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : apb_cfg_seq_fifo
// Description : Show-ahead synchronous FIFO that holds queued commands.
//               It ignores a push while full and a pop while empty. A push
//               and a pop on the same edge leave the count unchanged.
// Ports       : clk, rst    - clock, synchronous active-high reset
//               i_push/i_data - write side
//               i_pop/o_data  - read side (o_data is the current head)
//               o_full/o_empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module apb_cfg_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == c_CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : apb_cfg_seq
// Description : Queues configuration commands and runs each one as a single
//               APB transfer. It returns one response per command with a
//               2-bit error code (00 OK, 01 SLVERR, 10 TIMEOUT, 11 MISMATCH).
//               Only one APB transfer is outstanding at a time.
// Macro       : APB_CFG_SEQ_READBACK_EN - when defined, each successful write
//               is followed by a read of the same address. The read data is
//               compared with the write data under RB_MASK.
// Ports       : HCLK, HRESET           - clock, synchronous active-high reset
//               cmd_*                  - command channel (valid/ready)
//               rsp_*                  - response channel (valid/ready)
//               PADDR..PSLVERR         - APB master
//               busy_o                 - FSM active or commands queued
// Revision    : 1.0 - initial release
// ============================================================================
module apb_cfg_seq
  import apb_cfg_seq_pkg::*;
#(
  parameter int          APB_ADDR_WIDTH = 12,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          TIMEOUT        = 16,
  parameter logic [31:0] RB_MASK        = 32'h7FFF_FFFF
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]               cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic [1:0]                rsp_err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic                      busy_o
);

  localparam int c_TMO_W = $clog2(TIMEOUT + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  cmd_t               r_cmd;
  cmd_t               w_cmd_in;
  cmd_t               w_fifo_head;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_pop;
  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic               w_tmo_hit;
  logic               w_in_setup;
  logic               w_in_access;
  logic               w_rsp_load;
  err_e               w_rsp_err_nxt;
  logic [31:0]        w_rsp_rdata_nxt;
  err_e               r_rsp_err;
  logic [31:0]        r_rsp_rdata;

  always_comb begin
    w_cmd_in                          = '0;
    w_cmd_in.write                    = cmd_write_i;
    w_cmd_in.addr[APB_ADDR_WIDTH-1:0] = cmd_addr_i;
    w_cmd_in.wdata                    = cmd_wdata_i;
  end

  apb_cfg_seq_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (HCLK),
    .rst     (HRESET),
    .i_push  (cmd_valid_i),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

`ifdef APB_CFG_SEQ_READBACK_EN
  assign w_in_setup  = (r_state == ST_SETUP)  || (r_state == ST_RB_SETUP);
  assign w_in_access = (r_state == ST_ACCESS) || (r_state == ST_RB_ACCESS);
`else
  assign w_in_setup  = (r_state == ST_SETUP);
  assign w_in_access = (r_state == ST_ACCESS);
`endif

  // This is the TIMEOUT-th ACCESS cycle with PREADY low.
  assign w_tmo_hit = (r_tmo_cnt == c_TMO_W'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_rsp_load      = 1'b0;
    w_rsp_err_nxt   = ERR_OK;
    w_rsp_rdata_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR) begin
            w_rsp_load    = 1'b1;
            w_rsp_err_nxt = ERR_SLVERR;
            w_state_nxt   = ST_RESP;
          end
`ifdef APB_CFG_SEQ_READBACK_EN
          else if (r_cmd.write) begin
            w_state_nxt = ST_RB_SETUP;
          end
`endif
          else begin
            w_rsp_load      = 1'b1;
            w_rsp_rdata_nxt = r_cmd.write ? 32'd0 : PRDATA;
            w_state_nxt     = ST_RESP;
          end
        end else if (w_tmo_hit) begin
          w_rsp_load    = 1'b1;
          w_rsp_err_nxt = ERR_TIMEOUT;
          w_state_nxt   = ST_RESP;
        end
      end
`ifdef APB_CFG_SEQ_READBACK_EN
      ST_RB_SETUP: w_state_nxt = ST_RB_ACCESS;
      ST_RB_ACCESS: begin
        if (PREADY) begin
          w_rsp_load  = 1'b1;
          w_state_nxt = ST_RESP;
          if (PSLVERR) begin
            w_rsp_err_nxt = ERR_SLVERR;
          end else begin
            w_rsp_rdata_nxt = PRDATA;
            w_rsp_err_nxt   = rb_mismatch(PRDATA, r_cmd.wdata, RB_MASK) ?
                              ERR_MISMATCH : ERR_OK;
          end
        end else if (w_tmo_hit) begin
          w_rsp_load    = 1'b1;
          w_rsp_err_nxt = ERR_TIMEOUT;
          w_state_nxt   = ST_RESP;
        end
      end
`endif
      ST_RESP: begin
        if (rsp_ready_i) begin
          // Go straight to the next queued command without an IDLE bubble.
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_SETUP;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_tmo_cnt   <= '0;
      r_rsp_err   <= ERR_OK;
      r_rsp_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_cmd <= w_fifo_head;
      end
      if (w_rsp_load) begin
        r_rsp_err   <= w_rsp_err_nxt;
        r_rsp_rdata <= w_rsp_rdata_nxt;
      end
      // Every ACCESS phase is preceded by a SETUP cycle, so clearing there
      // restarts the count on each entry to ACCESS.
      if (w_in_setup) begin
        r_tmo_cnt <= '0;
      end else if (w_in_access && !PREADY) begin
        r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
      end
    end
  end

  assign PSEL        = w_in_setup || w_in_access;
  assign PENABLE     = w_in_access;
  assign PADDR       = r_cmd.addr[APB_ADDR_WIDTH-1:0];
  assign PWDATA      = r_cmd.wdata;
  // PWRITE is low during the readback phases.
  assign PWRITE      = r_cmd.write && ((r_state == ST_SETUP) || (r_state == ST_ACCESS));
  assign rsp_valid_o = (r_state == ST_RESP);
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign cmd_ready_o = !w_fifo_full;
  assign busy_o      = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire
